pipe_skid_stage: RTL and testbench

//  Parametrised pipeline boundary register for EX/MEM-class interfaces.

---
 rtl/pipe_skid_stage_pkg.sv | 16 +
 rtl/pipe_skid_stage_if.sv | 14 +
 rtl/pipe_skid_stage.sv | 120 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the pipeline boundary registers: occupancy
// state encoding and default field widths used by every stage instance.
package pipe_skid_stage_pkg;

    localparam int CTRL_W_DEF = 8;
    localparam int DATA_W_DEF = 134;
    localparam int CNT_W_DEF  = 16;

    // Occupancy of the boundary register: 0, 1 (main) or 2 (main + skid).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready stage-boundary bus carrying a control field and a payload.
// The master drives valid/ctrl/data; the slave drives ready.
interface pipe_skid_stage_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 134
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input  ready);
    modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// Pipeline boundary register with a 2-entry skid buffer, synchronous
// flush that squashes held entries, and a saturating stall counter.
// Entry 0 is the head (main) register, entry 1 the skid register.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Flush,
    pipe_skid_stage_if.slave   up,
    pipe_skid_stage_if.master  dn,
    output logic [CNT_W-1:0]   StallCount
);

    localparam int MAIN = 0;
    localparam int SKID = 1;

    state_t state_q, state_d;
    logic   ready_q;
    logic   in_fire, out_fire;
    logic   ld_main_in, ld_main_skid, ld_skid_in;

    logic [1:0][CTRL_W-1:0] ctrl_q;
    logic [1:0][DATA_W-1:0] data_q;

    assign in_fire  = up.valid & up.ready;
    assign out_fire = dn.valid & dn.ready;

    // Next occupancy and which register loads what; flush overrides all.
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d    = BUSY;
                    ld_main_in = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    ld_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d    = FULL;
                    ld_skid_in = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d      = BUSY;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (Flush) begin
            state_d      = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid_in   = 1'b0;
        end
    end

    // Occupancy state; ready is registered so it never depends on dn.ready.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != FULL);
        end
    end

    // Main and skid entry registers; flush clears control so no stale
    // write enable can survive into a later bubble.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else if (Flush) begin
            ctrl_q <= '0;
        end else begin
            if (ld_main_in) begin
                ctrl_q[MAIN] <= up.ctrl;
                data_q[MAIN] <= up.data;
            end else if (ld_main_skid) begin
                ctrl_q[MAIN] <= ctrl_q[SKID];
                data_q[MAIN] <= data_q[SKID];
            end
            if (ld_skid_in) begin
                ctrl_q[SKID] <= up.ctrl;
                data_q[SKID] <= up.data;
            end
        end
    end

    // Saturating count of cycles the head is offered but not taken.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            StallCount <= '0;
        end else if (dn.valid && !dn.ready && (StallCount != '1)) begin
            StallCount <= StallCount + 1'b1;
        end
    end

    assign up.ready = ready_q;
    assign dn.valid = (state_q != EMPTY);
    assign dn.ctrl  = dn.valid ? ctrl_q[MAIN] : '0;
    assign dn.data  = data_q[MAIN];

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench: a queue-based occupancy model checked against the
// DUT every falling edge, plus hand-computed literal expectations.
module tb_pipe_skid_stage;
    localparam int CTRL_W = 8;
    localparam int DATA_W = 134;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic Clk = 1'b0;
    logic Rst_n = 1'b1;
    logic Flush = 1'b0;
    logic InValid = 1'b0;
    logic OutReady = 1'b0;
    logic [CTRL_W-1:0] InCtrl = '0;
    logic [DATA_W-1:0] InData = '0;
    logic [CNT_W-1:0]  StallCount;

    int checks = 0;
    int errors = 0;

    pipe_skid_stage_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) up_if ();
    pipe_skid_stage_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dn_if ();

    assign up_if.valid = InValid;
    assign up_if.ctrl  = InCtrl;
    assign up_if.data  = InData;
    assign dn_if.ready = OutReady;

    pipe_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Flush      (Flush),
        .up         (up_if.slave),
        .dn         (dn_if.master),
        .StallCount (StallCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two entries; ready means room for one more.
    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;
    ent_t q[$];
    int   mcnt = 0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            q.delete();
            mcnt = 0;
        end else begin
            automatic int n   = q.size();
            automatic bit inf = InValid && (n < 2);
            automatic bit otf = (n > 0) && OutReady;
            if ((n > 0) && !OutReady && (mcnt < CMAX)) mcnt++;
            if (otf) void'(q.pop_front());
            if (Flush) q.delete();
            else if (inf) q.push_back({InCtrl, InData});
        end
    end

    always @(negedge Clk) begin
        chk("m_out_valid", 256'(dn_if.valid), 256'(q.size() > 0));
        chk("m_in_ready", 256'(up_if.ready), 256'(q.size() < 2));
        chk("m_stall_cnt", 256'(StallCount), 256'(mcnt));
        if (q.size() > 0) begin
            chk("m_out_ctrl", 256'(dn_if.ctrl), 256'(q[0].c));
            chk("m_out_data", 256'(dn_if.data), 256'(q[0].d));
        end else begin
            chk("m_bubble_ctrl", 256'(dn_if.ctrl), 256'(0));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [CTRL_W-1:0] c, input int d);
        InValid = 1'b1;
        InCtrl  = c;
        InData  = DATA_W'(d);
    endtask

    initial begin
        // power-on reset
        #1 Rst_n = 1'b0;
        #2;
        chk("rst_valid", 256'(dn_if.valid), 256'(0));
        chk("rst_ready", 256'(up_if.ready), 256'(1));
        chk("rst_cnt", 256'(StallCount), 256'(0));
        step();
        step();
        Rst_n = 1'b1;
        step();

        // streaming: full rate, one-cycle latency, no gaps
        OutReady = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            push(8'h81, i);
            step();
            chk("stream_data", 256'(dn_if.data), 256'(i));
            chk("stream_ctrl", 256'(dn_if.ctrl), 256'(8'h81));
            chk("stream_ready", 256'(up_if.ready), 256'(1));
        end
        InValid = 1'b0;
        step();
        chk("stream_drained", 256'(dn_if.valid), 256'(0));

        // back-pressure: A=5, B=6 fill, C=7 held upstream
        OutReady = 1'b0;
        push(8'h11, 5);
        step();
        push(8'h12, 6);
        step();
        chk("bp_full_ready", 256'(up_if.ready), 256'(0));
        push(8'h13, 7);
        step();
        step();
        chk("bp_cnt", 256'(StallCount), 256'(3));
        chk("bp_head", 256'(dn_if.data), 256'(5));
        OutReady = 1'b1;
        step();
        chk("bp_second", 256'(dn_if.data), 256'(6));
        step();
        InValid = 1'b0;
        chk("bp_third", 256'(dn_if.data), 256'(7));
        step();
        chk("bp_empty", 256'(dn_if.valid), 256'(0));

        // flush from FULL, input presented in flush cycle
        OutReady = 1'b0;
        push(8'hFF, 1);
        step();
        push(8'hFF, 2);
        step();
        push(8'hFF, 9);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        InValid = 1'b0;
        chk("fl_valid", 256'(dn_if.valid), 256'(0));
        chk("fl_ctrl", 256'(dn_if.ctrl), 256'(0));
        chk("fl_ready", 256'(up_if.ready), 256'(1));
        chk("fl_cnt", 256'(StallCount), 256'(5));
        OutReady = 1'b1;
        step();
        chk("fl_no9", 256'(dn_if.valid), 256'(0));

        // flush from BUSY while an input is accepted: it is dropped
        push(8'hFF, 3);
        OutReady = 1'b0;
        step();
        push(8'hFF, 9);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        InValid = 1'b0;
        chk("flb_valid", 256'(dn_if.valid), 256'(0));
        OutReady = 1'b1;
        step();
        step();
        chk("flb_no9", 256'(dn_if.valid), 256'(0));

        // saturation: head stalled for 20 cycles
        OutReady = 1'b0;
        push(8'h22, 42);
        step();
        InValid = 1'b0;
        repeat (20) step();
        chk("sat_cnt", 256'(StallCount), 256'(15));
        chk("sat_hold", 256'(dn_if.data), 256'(42));
        OutReady = 1'b1;
        step();

        // simultaneous in/out fire while occupied
        for (int i = 0; i < 8; i++) begin
            push(8'h40, 100 + i);
            step();
            chk("sim_data", 256'(dn_if.data), 256'(100 + i));
            chk("sim_ready", 256'(up_if.ready), 256'(1));
        end
        InValid = 1'b0;
        step();

        // async reset with two entries held
        OutReady = 1'b0;
        push(8'h77, 1);
        step();
        push(8'h77, 2);
        step();
        InValid = 1'b0;
        Rst_n = 1'b0;
        #1;
        chk("ar_valid", 256'(dn_if.valid), 256'(0));
        chk("ar_ctrl", 256'(dn_if.ctrl), 256'(0));
        chk("ar_ready", 256'(up_if.ready), 256'(1));
        chk("ar_cnt", 256'(StallCount), 256'(0));
        step();
        Rst_n = 1'b1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
